// File: rtl/ofifo_skew_if.sv
//------------------------------------------------------------------------------
// Module : ofifo_skew_if
// Brief  : Row-write / row-read bundle for the skewed output FIFO.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ofifo_skew_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
);
    logic [col*psum_bw-1:0]  in;
    logic                    wr;
    logic                    rd;
    logic [col*psum_bw-1:0]  out;
    logic                    o_valid;
    logic                    o_full;
    logic                    o_ready;
    logic                    o_almost_full;
    logic [$clog2(depth):0]  o_count;
    logic                    o_overflow;

    modport master (
        output in, wr, rd,
        input  out, o_valid, o_full, o_ready, o_almost_full, o_count, o_overflow
    );

    modport slave (
        input  in, wr, rd,
        output out, o_valid, o_full, o_ready, o_almost_full, o_count, o_overflow
    );
endinterface

`default_nettype wire

// File: rtl/ofifo_skew.sv
//------------------------------------------------------------------------------
// Module : ofifo_skew
// Brief  : Per-column circular buffers with diagonal (skewed) write and a shared
//          first-word-fall-through read pointer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ofifo_skew #(
    parameter int col      = 8,
    parameter int psum_bw  = 16,
    parameter int depth    = 64,
    parameter int skew     = 1,
    parameter int af_level = depth - 4
) (
    input  wire logic    clk,
    input  wire logic    reset,
    ofifo_skew_if.slave  bus
);
    localparam int             c_AW      = $clog2(depth);
    localparam logic [c_AW:0]  c_DEPTH_W = (c_AW+1)'(depth);
    localparam logic [c_AW:0]  c_AF_W    = (c_AW+1)'(af_level);

    logic [col-1:0]  w_we;
    logic [col-1:0]  w_full;
    logic [col-1:0]  w_wacc;
    logic [c_AW:0]   w_count;
    logic            w_rd_acc;
    logic [c_AW-1:0] r_rptr;
    logic            r_overflow;

    // A row is popped only when the last column holds a complete entry.
    assign w_rd_acc = bus.rd && bus.o_valid;

    generate
        if (skew != 0) begin : g_skew
            logic [col-2:0] r_tok;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_tok <= '0;
                end else begin
                    r_tok <= (col-1)'({r_tok, bus.wr});
                end
            end

            assign w_we = {r_tok, bus.wr};
        end else begin : g_aligned
            assign w_we = {col{bus.wr}};
        end
    endgenerate

    generate
        for (genvar i = 0; i < col; i++) begin : g_col
            logic [c_AW-1:0]    r_wptr;
            logic [c_AW:0]      r_occ;
            logic [psum_bw-1:0] r_mem [depth];

            assign w_full[i] = (r_occ == c_DEPTH_W);
            // A full column still takes the write when a pop frees a slot.
            assign w_wacc[i] = w_we[i] && (!w_full[i] || w_rd_acc);

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_wptr <= '0;
                    r_occ  <= '0;
                end else begin
                    if (w_wacc[i]) begin
                        r_wptr <= r_wptr + 1'b1;
                    end
                    r_occ <= r_occ + (c_AW+1)'(w_wacc[i]) - (c_AW+1)'(w_rd_acc);
                end
            end

            always_ff @(posedge clk) begin
                if (!reset && w_wacc[i]) begin
                    r_mem[r_wptr] <= bus.in[i*psum_bw +: psum_bw];
                end
            end

            assign bus.out[i*psum_bw +: psum_bw] = r_mem[r_rptr];

            if (i == col - 1) begin : g_last
                assign w_count = r_occ;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_rd_acc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (|(w_we & ~w_wacc)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.o_count       = w_count;
    assign bus.o_valid       = (w_count != '0);
    assign bus.o_full        = |w_full;
    assign bus.o_ready       = ~(|w_full);
    assign bus.o_almost_full = (w_count >= c_AF_W);
    assign bus.o_overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_ofifo_skew.sv
//------------------------------------------------------------------------------
// Module : tb_ofifo_skew
// Brief  : Directed bench for ofifo_skew (skewed and aligned instances).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ofifo_skew;
    localparam int c_COL = 8;
    localparam int c_BW  = 16;
    localparam int c_DEP = 64;
    localparam int c_W   = c_COL * c_BW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   next_id = 0;
    int   hist [c_COL];
    logic [c_W-1:0] sb [$];

    always #5 clk = ~clk;

    ofifo_skew_if #(.col(c_COL), .psum_bw(c_BW), .depth(c_DEP)) bus ();
    ofifo_skew_if #(.col(c_COL), .psum_bw(c_BW), .depth(c_DEP)) bus0 ();

    ofifo_skew #(.col(c_COL), .psum_bw(c_BW), .depth(c_DEP), .skew(1), .af_level(c_DEP-4))
        dut (.clk(clk), .reset(reset), .bus(bus));

    ofifo_skew #(.col(c_COL), .psum_bw(c_BW), .depth(c_DEP), .skew(0), .af_level(c_DEP-4))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));

    task automatic chk(input string tag, input logic [c_W-1:0] obs, input logic [c_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [c_BW-1:0] word_of(input int id, input int c);
        logic [c_BW-1:0] w;
        w = {id[11:0], c[3:0]};
        return w;
    endfunction

    function automatic logic [c_W-1:0] row_of(input int id);
        logic [c_W-1:0] r;
        for (int c = 0; c < c_COL; c++) r[c*c_BW +: c_BW] = word_of(id, c);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of the skewed DUT: column c sees the data of the beat issued c cycles ago.
    task automatic step(input bit w, input bit r, input bit keep);
        int id;
        logic [c_W-1:0] v;
        id = -1;
        if (r) begin
            chk("rd_valid", c_W'(bus.o_valid), c_W'(1));
            if (sb.size() > 0) chk("rd_data", bus.out, sb.pop_front());
            else chk("rd_sb_empty", c_W'(sb.size()), c_W'(1));
        end
        if (w) begin
            id = next_id;
            next_id++;
            if (keep) sb.push_back(row_of(id));
        end
        for (int k = c_COL-1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = id;
        for (int c = 0; c < c_COL; c++)
            v[c*c_BW +: c_BW] = (hist[c] >= 0) ? word_of(hist[c], c) : 16'hDEAD;
        bus.in = v;
        bus.wr = w;
        bus.rd = r;
        tick();
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        bus0.wr = 1'b0;
        bus0.rd = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < c_COL; k++) hist[k] = -1;
        sb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        bus.in = '0;
        bus0.in = '0;
        do_reset();

        // Reset state
        chk("rst_valid",  c_W'(bus.o_valid),       c_W'(0));
        chk("rst_count",  c_W'(bus.o_count),       c_W'(0));
        chk("rst_full",   c_W'(bus.o_full),        c_W'(0));
        chk("rst_ready",  c_W'(bus.o_ready),       c_W'(1));
        chk("rst_afull",  c_W'(bus.o_almost_full), c_W'(0));
        chk("rst_ovf",    c_W'(bus.o_overflow),    c_W'(0));

        // Single skewed write: valid only after the last column's edge
        step(1, 0, 1);
        for (int k = 0; k < 6; k++) step(0, 0, 0);
        chk("single_not_yet", c_W'(bus.o_valid), c_W'(0));
        step(0, 0, 0);
        chk("single_valid", c_W'(bus.o_valid), c_W'(1));
        chk("single_count", c_W'(bus.o_count), c_W'(1));
        step(0, 1, 0);
        chk("single_drained", c_W'(bus.o_count), c_W'(0));

        // Fill: 64 back-to-back beats
        for (int k = 0; k < 63; k++) step(1, 0, 1);
        chk("fill_full_63", c_W'(bus.o_full), c_W'(0));
        step(1, 0, 1);
        chk("fill_full_64", c_W'(bus.o_full),  c_W'(1));
        chk("fill_ready",   c_W'(bus.o_ready), c_W'(0));
        chk("fill_count57", c_W'(bus.o_count), c_W'(57));
        step(0, 0, 0);
        step(0, 0, 0);
        chk("afull_at59", c_W'(bus.o_almost_full), c_W'(0));
        step(0, 0, 0);
        chk("afull_at60", c_W'(bus.o_almost_full), c_W'(1));
        for (int k = 0; k < 4; k++) step(0, 0, 0);
        chk("fill_count64", c_W'(bus.o_count),    c_W'(64));
        chk("fill_no_ovf",  c_W'(bus.o_overflow), c_W'(0));

        // Extra write into a full FIFO is dropped in every column
        step(1, 0, 0);
        chk("ovf_set", c_W'(bus.o_overflow), c_W'(1));
        for (int k = 0; k < 7; k++) step(0, 0, 0);
        chk("ovf_hold",  c_W'(bus.o_overflow), c_W'(1));
        chk("ovf_count", c_W'(bus.o_count),    c_W'(64));
        for (int k = 0; k < 64; k++) step(0, 1, 0);
        chk("ovf_drained", c_W'(bus.o_count),    c_W'(0));
        chk("ovf_sticky",  c_W'(bus.o_overflow), c_W'(1));

        do_reset();
        chk("ovf_cleared", c_W'(bus.o_overflow), c_W'(0));

        // Half full, then simultaneous wr/rd long enough to wrap pointers
        for (int k = 0; k < 32; k++) step(1, 0, 1);
        for (int k = 0; k < 7; k++) step(0, 0, 0);
        chk("half_count", c_W'(bus.o_count), c_W'(32));
        for (int k = 0; k < 200; k++) begin
            step(1, 1, 1);
            if (k == 50) chk("stream_count_mid", c_W'(bus.o_count), c_W'(25));
        end
        chk("stream_count_end", c_W'(bus.o_count), c_W'(25));
        for (int k = 0; k < 7; k++) step(0, 0, 0);
        chk("stream_count_settled", c_W'(bus.o_count), c_W'(32));
        for (int k = 0; k < 32; k++) step(0, 1, 0);
        chk("stream_drained", c_W'(bus.o_count), c_W'(0));
        chk("stream_no_ovf", c_W'(bus.o_overflow), c_W'(0));

        // Reset in the middle of a skewed write discards the pending tokens
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        do_reset();
        for (int k = 0; k < 8; k++) step(0, 0, 0);
        chk("midrst_valid", c_W'(bus.o_valid), c_W'(0));
        chk("midrst_count", c_W'(bus.o_count), c_W'(0));
        step(1, 0, 1);
        for (int k = 0; k < 7; k++) step(0, 0, 0);
        chk("midrst_valid2", c_W'(bus.o_valid), c_W'(1));
        chk("midrst_count2", c_W'(bus.o_count), c_W'(1));
        step(0, 1, 0);
        chk("midrst_drained", c_W'(bus.o_count), c_W'(0));

        // Aligned instance: read on empty ignored, write visible next cycle
        bus0.rd = 1'b1;
        tick();
        bus0.rd = 1'b0;
        chk("al_rd_empty_count", c_W'(bus0.o_count), c_W'(0));
        chk("al_rd_empty_valid", c_W'(bus0.o_valid), c_W'(0));
        bus0.in = {c_COL{16'hAAAA}};
        bus0.wr = 1'b1;
        tick();
        bus0.wr = 1'b0;
        bus0.in = '0;
        chk("al_valid", c_W'(bus0.o_valid), c_W'(1));
        chk("al_count", c_W'(bus0.o_count), c_W'(1));
        chk("al_data",  bus0.out, {c_COL{16'hAAAA}});
        bus0.rd = 1'b1;
        tick();
        bus0.rd = 1'b0;
        chk("al_drained", c_W'(bus0.o_count), c_W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
